mdu_core: RTL and testbench

- Multiply/divide unit in the E stage of the 5-stage MIPS pipeline.
- Owns HI/LO and executes mult/multu/div/divu with multi-cycle latency; services mfhi/mflo/mthi/mtlo.
- Produces the busy indication consumed by the hazard unit, which stalls md/mt/mf instructions in D while busy is high.

---
 rtl/mdu_pkg.sv | 43 ++++
 rtl/mdu_arith.sv | 54 +++++
 rtl/mdu_core.sv | 125 ++++++++++++
 tb/tb_mdu_core.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared types and constants for the multiply/divide unit.
// Pure definitions, no logic or latency.
// Not applicable (no handshake).
package mdu_pkg;

  // Op codes shared with the E-stage controller
  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  localparam int MDU_MULT_CYCLES_DEF = 5;
  localparam int MDU_DIV_CYCLES_DEF  = 10;
  localparam int MDU_CNT_W           = 8;

  // Pending HI/LO result; wr=0 means leave HI/LO untouched (divide by zero)
  typedef struct packed {
    logic        wr;
    logic [31:0] hi;
    logic [31:0] lo;
  } mdu_res_t;

  function automatic logic is_md_op(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic is_mult_op(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational 64-bit HI/LO result generator for mult/multu/div/divu.
// Zero latency; the sequencer decides when the result is committed.
// No backpressure; output is a pure function of op and operands.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output mdu_res_t    res
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic        b_zero;

  // Signed division works on magnitudes so 0x80000000 / -1 falls out as
  // quotient 0x80000000, remainder 0 without a special case.
  always_comb begin
    a_neg  = a[31];
    b_neg  = b[31];
    a_mag  = a_neg ? (32'd0 - a) : a;
    b_mag  = b_neg ? (32'd0 - b) : b;
    b_zero = (b == 32'd0);
    q_mag  = b_zero ? 32'd0 : (a_mag / b_mag);
    r_mag  = b_zero ? 32'd0 : (a_mag % b_mag);
    prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    prod_u = {32'd0, a} * {32'd0, b};

    res = '0;
    case (op)
      MDU_MULT:  res = {1'b1, prod_s[63:32], prod_s[31:0]};
      MDU_MULTU: res = {1'b1, prod_u[63:32], prod_u[31:0]};
      MDU_DIV: begin
        res.wr = !b_zero;
        res.lo = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        res.hi = a_neg ? (32'd0 - r_mag) : r_mag;
      end
      MDU_DIVU: begin
        res.wr = !b_zero;
        res.lo = b_zero ? 32'd0 : (a / b);
        res.hi = b_zero ? 32'd0 : (a % b);
      end
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/mdu_core.sv
// HI/LO owner and multi-cycle sequencer for mult/div; mthi/mtlo/mfhi/mflo. Optional MDU_CANCEL_EN adds cancel.
// mult: busy for start cycle + MULT_CYCLES; div: start cycle + DIV_CYCLES; mthi/mtlo single cycle.
// busy stalls md/mt/mf in D; start or mt* while already busy is ignored (assertion flags it).
module mdu_core
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
`ifdef MDU_CANCEL_EN
  input  logic        cancel,
`endif
  output logic        busy,
  output logic [31:0] mdu_out,
  output logic [31:0] hi_q,
  output logic [31:0] lo_q
);

  mdu_state_e           state_q, state_d;
  logic [MDU_CNT_W-1:0] cnt_q, cnt_d;
  logic                 busy_reg, busy_d;
  mdu_res_t             pend_q, pend_d;
  mdu_res_t             res_w;
  logic [31:0]          hi_d, lo_d;
  logic                 cancel_w;

`ifdef MDU_CANCEL_EN
  assign cancel_w = cancel;
`else
  assign cancel_w = 1'b0;
`endif

  mdu_arith u_arith (
    .op  (mdu_op),
    .a   (A),
    .b   (B),
    .res (res_w)
  );

  // Next-state: launch in IDLE, count down in RUN, commit HI/LO on the last count
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_reg;
    pend_d  = pend_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (!cancel_w) begin
          if (start && is_md_op(mdu_op)) begin
            pend_d  = res_w;
            cnt_d   = is_mult_op(mdu_op) ? MDU_CNT_W'(MULT_CYCLES) : MDU_CNT_W'(DIV_CYCLES);
            busy_d  = 1'b1;
            state_d = ST_RUN;
          end else if (!start && (mdu_op == MDU_MTHI)) begin
            hi_d = A;
          end else if (!start && (mdu_op == MDU_MTLO)) begin
            lo_d = A;
          end
        end
      end
      ST_RUN: begin
        if (cancel_w) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
          pend_d  = '0;
        end else if (cnt_q == MDU_CNT_W'(1)) begin
          if (pend_q.wr) begin
            hi_d = pend_q.hi;
            lo_d = pend_q.lo;
          end
          state_d = ST_IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
          pend_d  = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counter, pending result and HI/LO registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      busy_reg <= 1'b0;
      pend_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_reg <= busy_d;
      pend_q   <= pend_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // Hazard-unit busy and mfhi/mflo read mux
  always_comb begin
    busy = start | busy_reg;
    case (mdu_op)
      MDU_MFHI: mdu_out = hi_q;
      MDU_MFLO: mdu_out = lo_q;
      default:  mdu_out = 32'd0;
    endcase
  end

  // The hazard unit must never let a new md/mt op reach E while running
  a_no_issue_while_busy: assert property (@(posedge clk) disable iff (reset)
    busy_reg |-> !(start || (mdu_op == MDU_MTHI) || (mdu_op == MDU_MTLO)));

endmodule

// File: tb/tb_mdu_core.sv
module tb_mdu_core;
  import mdu_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  mdu_op;
  logic [31:0] A, B;
  logic        busy;
  logic [31:0] mdu_out, hi_q, lo_q;
`ifdef MDU_CANCEL_EN
  logic        cancel;
`endif

  mdu_core dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .mdu_op  (mdu_op),
    .A       (A),
    .B       (B),
`ifdef MDU_CANCEL_EN
    .cancel  (cancel),
`endif
    .busy    (busy),
    .mdu_out (mdu_out),
    .hi_q    (hi_q),
    .lo_q    (lo_q)
  );

  always #5 clk = ~clk;

  // kind 0: busy window ends -> HI/LO and window length; kind 1: mdu_out read
  typedef struct {
    int          kind;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  logic        mon_en = 1'b0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference model: plain 64-bit arithmetic
  task automatic model_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, q, r;
    longint unsigned p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      MDU_MULT:  begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
      MDU_MULTU: begin p = {32'd0, a} * {32'd0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
      MDU_DIV: if (b != 0) begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; end
      MDU_DIVU: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
      default: ;
    endcase
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      if (busy === 1'b0) return;
      @(posedge clk); #1;
    end
    total++; bad++;
    $display("FAIL busy_timeout actual=busy_stuck required=idle_within_60");
  endtask

  task automatic do_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    @(posedge clk); #1;
    start = 1'b1; mdu_op = op; A = a; B = b;
    model_md(op, a, b);
    e.kind = 0; e.hi = m_hi; e.lo = m_lo;
    e.cyc = ((op == MDU_MULT) || (op == MDU_MULTU)) ? MC + 1 : DC + 1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0; mdu_op = MDU_NONE; A = $urandom; B = $urandom;
    wait_idle();
  endtask

  task automatic do_rd(input logic [3:0] op);
    exp_t e;
    @(posedge clk); #1;
    mdu_op = op;
    e.kind = 1; e.lo = 32'd0; e.cyc = 0;
    e.hi = (op == MDU_MFHI) ? m_hi : (op == MDU_MFLO) ? m_lo : 32'd0;
    exp_q.push_back(e);
    @(posedge clk); #1;
    mdu_op = MDU_NONE;
  endtask

  task automatic do_mt(input logic [3:0] op, input logic [31:0] v);
    @(posedge clk); #1;
    mdu_op = op; A = v;
    if (op == MDU_MTHI) m_hi = v; else m_lo = v;
    @(posedge clk); #1;
    mdu_op = MDU_NONE;
  endtask

  // Monitor: pops an expectation whenever a busy window closes or a read is presented
  initial begin
    int   bcnt;
    exp_t e;
    bcnt = 0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        bcnt = 0;
      end else if (busy === 1'b1) begin
        bcnt++;
      end else begin
        if (bcnt > 0) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_busy_end actual=%0d_cycles required=no_op", bcnt);
          end else begin
            e = exp_q.pop_front();
            chk("md_order", 32'(e.kind), 32'd0);
            chk("md_hi", hi_q, e.hi);
            chk("md_lo", lo_q, e.lo);
            chk("md_busy_cycles", 32'(bcnt), 32'(e.cyc));
          end
          bcnt = 0;
        end
        if ((mdu_op == MDU_MFHI) || (mdu_op == MDU_MFLO) || (mdu_op > 4'd8)) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_read actual=%h required=no_read", mdu_out);
          end else begin
            e = exp_q.pop_front();
            chk("rd_order", 32'(e.kind), 32'd1);
            chk("mdu_out", mdu_out, e.hi);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t        e;
    int          r;
    logic [31:0] ra, rb;
    reset = 1'b1; start = 1'b0; mdu_op = MDU_NONE; A = 32'd0; B = 32'd0;
`ifdef MDU_CANCEL_EN
    cancel = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_hi", hi_q, 32'd0);
    chk("reset_lo", lo_q, 32'd0);
    chk("reset_out", mdu_out, 32'd0);
    mon_en = 1'b1;

    do_md(MDU_MULT, 32'hFFFFFFFD, 32'd5);
    do_rd(MDU_MFHI);
    do_rd(MDU_MFLO);
    do_md(MDU_MULTU, 32'hFFFFFFFF, 32'd2);
    do_md(MDU_DIV, 32'hFFFFFFF9, 32'd2);
    do_md(MDU_DIVU, 32'd7, 32'd2);
    do_mt(MDU_MTHI, 32'h11);
    do_mt(MDU_MTLO, 32'h22);
    do_md(MDU_DIVU, 32'd1234, 32'd0);
    do_rd(MDU_MFHI);
    do_md(MDU_DIV, 32'h80000000, 32'hFFFFFFFF);
    do_rd(MDU_MFLO);
    do_rd(4'hF);

    // Reset in the third busy cycle of a div discards the result
    @(posedge clk); #1;
    start = 1'b1; mdu_op = MDU_DIV; A = 32'd100; B = 32'd7;
    m_hi = 32'd0; m_lo = 32'd0;
    e.kind = 0; e.hi = 32'd0; e.lo = 32'd0; e.cyc = 3;
    exp_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0; mdu_op = MDU_NONE;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    wait_idle();
    do_md(MDU_MULT, 32'd2, 32'd3);
    do_rd(MDU_MFLO);

`ifdef MDU_CANCEL_EN
    do_mt(MDU_MTLO, 32'h55);
    @(posedge clk); #1;
    start = 1'b1; mdu_op = MDU_MULT; A = 32'd9; B = 32'd9;
    e.kind = 0; e.hi = m_hi; e.lo = m_lo; e.cyc = 2;
    exp_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0; mdu_op = MDU_NONE; cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    wait_idle();
    do_rd(MDU_MFLO);
    @(posedge clk); #1;
    mdu_op = MDU_MTHI; A = 32'hDEAD; cancel = 1'b1;
    @(posedge clk); #1;
    mdu_op = MDU_NONE; cancel = 1'b0;
    do_rd(MDU_MFHI);
`endif

    for (int i = 0; i < 30; i++) begin
      r  = $urandom_range(0, 5);
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 20));
        2:       rb = 32'hFFFFFFFF;
        default: rb = $urandom;
      endcase
      if (r <= 3) begin
        do_md(4'(r + 1), ra, rb);
        do_rd(MDU_MFHI);
        do_rd(MDU_MFLO);
      end else if (r == 4) begin
        do_mt(($urandom_range(0, 1) == 0) ? MDU_MTHI : MDU_MTLO, ra);
      end else begin
        do_rd(($urandom_range(0, 1) == 0) ? MDU_MFHI : MDU_MFLO);
      end
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
